// File: rtl/tr_stream_arbiter_if.sv
// rtl/tr_stream_arbiter_if.sv - requester, output and status bundle for tr_stream_arbiter
// slave modport is the arbiter side; master is the environment driving it.
interface tr_stream_arbiter_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [DW-1:0]    req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [DW-1:0]    req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic             out_last;
    logic             out_src;
    logic             out_bad;
    logic [CNT_W-1:0] bad_count;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_last,
               out_src, out_bad, bad_count, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_last,
               out_src, out_bad, bad_count, busy
    );
endinterface

// File: rtl/tr_stream_arbiter.sv
// rtl/tr_stream_arbiter.sv - packet-locked two-requester round-robin arbiter
// Define TR_ARB_CRC_CHECK_EN to enable the XOR checksum check and bad-transaction counter.
module tr_stream_arbiter #(
    parameter int DW        = 32,
    parameter int PKT_WORDS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tr_stream_arbiter_if.slave    bus
);
    localparam int             BW        = $clog2(PKT_WORDS + 2);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_WORDS + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           grant;
    logic           last_grant;
    logic [BW-1:0]  beat;
    logic           any_req;
    logic           winner;
    logic           hs;
    logic           last_hs;

    assign any_req = bus.req0_valid | bus.req1_valid;
    // A tie goes to whoever did not win last; a lone requester always wins.
    assign winner  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    assign hs      = bus.out_valid && bus.out_ready;
    assign last_hs = hs && (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.out_src    = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_last   = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (state == GRANT) begin
            bus.busy       = 1'b1;
            bus.out_src    = grant;
            bus.out_valid  = grant ? bus.req1_valid : bus.req0_valid;
            bus.out_data   = grant ? bus.req1_data  : bus.req0_data;
            bus.out_last   = (beat == LAST_BEAT);
            bus.req0_ready = ~grant & bus.out_ready;
            bus.req1_ready =  grant & bus.out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat       <= '0;
        end else if (state == IDLE) begin
            beat <= '0;
            if (any_req) begin
                grant <= winner;
            end
        end else if (hs) begin
            if (beat == LAST_BEAT) begin
                beat       <= '0;
                last_grant <= grant;
            end else begin
                beat <= beat + BW'(1);
            end
        end
    end

`ifdef TR_ARB_CRC_CHECK_EN
    logic [DW-1:0]    acc;
    logic [CNT_W-1:0] bad_cnt;
    logic             bad_now;

    assign bad_now       = bus.out_last && (bus.out_data != acc);
    assign bus.out_bad   = bad_now;
    assign bus.bad_count = bad_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            bad_cnt <= '0;
        end else if (state == IDLE) begin
            acc <= '0;
        end else if (hs) begin
            if (beat == LAST_BEAT) begin
                acc <= '0;
                if (bad_now && (bad_cnt != {CNT_W{1'b1}})) begin
                    bad_cnt <= bad_cnt + CNT_W'(1);
                end
            end else begin
                acc <= acc ^ bus.out_data;
            end
        end
    end
`else
    assign bus.out_bad   = 1'b0;
    assign bus.bad_count = '0;
`endif

endmodule

// File: tb/tb_tr_stream_arbiter.sv
// tb/tb_tr_stream_arbiter.sv - randomized self-checking bench for tr_stream_arbiter
// Honours TR_ARB_CRC_CHECK_EN for the expected out_bad / bad_count behaviour.
module tb_tr_stream_arbiter;
    localparam int DW = 32;
    localparam int PW = 4;
    localparam int NB = PW + 2;
    localparam int CW = 5;
    localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef TR_ARB_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tr_stream_arbiter_if #(.DW(DW), .CNT_W(CW)) bus ();
    tr_stream_arbiter #(.DW(DW), .PKT_WORDS(PW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] drv_q0[$];
    logic [DW-1:0] drv_q1[$];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    bit            rdy_q[$];
    bit            order_q[$];
    int            p_valid = 100;
    int            p_rdy   = 100;
    bit            hs0, hs1;

    // Transaction-level reference: who owns the channel, which beat is next, running bad total.
    bit            m_busy = 1'b0;
    bit            m_src  = 1'b0;
    bit            m_last = 1'b1;
    bit            m_bad  = 1'b0;
    int            m_idx  = 0;
    int            m_done = 0;
    logic [CW-1:0] m_cnt  = '0;
    logic [DW-1:0] m_beats[NB];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input bit r, input logic [DW-1:0] d);
        if (r) begin drv_q1.push_back(d); exp_q1.push_back(d); end
        else   begin drv_q0.push_back(d); exp_q0.push_back(d); end
    endtask

    task automatic gen_tx(input bit r, input bit corrupt);
        logic [DW-1:0] d;
        logic [DW-1:0] x = '0;
        for (int i = 0; i < NB - 1; i++) begin
            d = $urandom;
            x ^= d;
            push_beat(r, d);
        end
        push_beat(r, corrupt ? (x ^ ($urandom | 32'h1)) : x);
    endtask

    task automatic monitor();
        bit v0, v1, sv, sr, orr;
        logic [DW-1:0] x;
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if (!rst_n) begin
            hs0 = 1'b0;
            hs1 = 1'b0;
            return;
        end
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        chk("bad_count", bus.bad_count, m_cnt);
        if (!m_busy) begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_readies", {bus.req0_ready, bus.req1_ready}, 0);
            if (v0 || v1) begin
                m_src  = (v0 && v1) ? !m_last : v1;
                m_busy = 1'b1;
                m_idx  = 0;
                chk("model_tx_available", (m_src ? exp_q1.size() : exp_q0.size()) >= NB, 1);
                x = '0;
                for (int i = 0; i < NB; i++) begin
                    if (m_src) m_beats[i] = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
                    else       m_beats[i] = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
                    if (i < NB - 1) x ^= m_beats[i];
                end
                m_bad = (x != m_beats[NB-1]);
                order_q.push_back(m_src);
            end
        end else begin
            sv  = m_src ? v1 : v0;
            sr  = m_src ? bus.req1_ready : bus.req0_ready;
            orr = m_src ? bus.req0_ready : bus.req1_ready;
            chk("grant_busy", bus.busy, 1);
            chk("grant_src", bus.out_src, m_src);
            chk("pass_valid", bus.out_valid, sv);
            chk("pass_ready", sr, bus.out_ready);
            chk("other_ready", orr, 0);
            if (bus.out_valid && bus.out_ready) begin
                chk("beat_data", bus.out_data, m_beats[m_idx]);
                chk("beat_last", bus.out_last, m_idx == NB - 1);
                if (m_idx == NB - 1) begin
                    chk("out_bad", bus.out_bad, CRC_EN ? m_bad : 1'b0);
                    if (CRC_EN && m_bad && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
                    m_last = m_src;
                    m_busy = 1'b0;
                    m_done++;
                end
                m_idx++;
            end
        end
    endtask

    task automatic drive();
        if (hs0) void'(drv_q0.pop_front());
        if (hs1) void'(drv_q1.pop_front());
        if (!rst_n) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            bus.out_ready  = 1'b0;
            return;
        end
        // A raised valid is held until its beat is taken.
        if (!(bus.req0_valid && !hs0)) begin
            if (drv_q0.size() > 0 && int'($urandom_range(99)) < p_valid) begin
                bus.req0_valid = 1'b1; bus.req0_data = drv_q0[0];
            end else begin
                bus.req0_valid = 1'b0; bus.req0_data = $urandom;
            end
        end
        if (!(bus.req1_valid && !hs1)) begin
            if (drv_q1.size() > 0 && int'($urandom_range(99)) < p_valid) begin
                bus.req1_valid = 1'b1; bus.req1_data = drv_q1[0];
            end else begin
                bus.req1_valid = 1'b0; bus.req1_data = $urandom;
            end
        end
        if (rdy_q.size() > 0) bus.out_ready = rdy_q.pop_front();
        else                  bus.out_ready = (int'($urandom_range(99)) < p_rdy);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until(input int target, input int bound, output int n);
        n = 0;
        while (m_done < target && n < bound) begin
            step();
            n++;
        end
        chk("timeout", m_done >= target, 1);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_last = 1'b1; m_cnt = '0; m_idx = 0;
        drv_q0.delete(); drv_q1.delete(); exp_q0.delete(); exp_q1.delete();
        rdy_q.delete(); order_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    logic [DW-1:0] pkt[NB];
    int            n;
    int            base;

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0;
        bus.out_ready  = 1'b0;
        pkt = '{32'h00010002, 32'd1, 32'd2, 32'd3, 32'd4, 32'h00010006};

        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_bad", bus.out_bad, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_src", bus.out_src, 0);
        chk("rst_bad_count", bus.bad_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie with continuous traffic: alternate starting from requester 0.
        for (int i = 0; i < 4; i++) begin gen_tx(0, 0); gen_tx(1, 0); end
        run_until(m_done + 8, 300, n);
        chk("tie_order_len", order_q.size(), 8);
        for (int i = 0; i < 4; i++) chk("tie_order", order_q[i], i % 2);

        // Single requester, known transaction, full-rate output.
        base = m_done;
        for (int i = 0; i < NB; i++) push_beat(0, pkt[i]);
        run_until(base + 1, 50, n);
        chk("single_cycles", n, 8);
        chk("single_src", order_q[order_q.size()-1], 0);
        chk("single_bad_count", bus.bad_count, 0);

        // Same transaction on requester 1 with a wrong checksum.
        base = m_done;
        for (int i = 0; i < NB - 1; i++) push_beat(1, pkt[i]);
        push_beat(1, 32'hDEADBEEF);
        run_until(base + 1, 50, n);
        chk("bad_count_after_bad", bus.bad_count, CRC_EN ? 1 : 0);

        // Back-pressure during payload while requester 0 shows up mid-transaction.
        base = m_done;
        for (int i = 0; i < NB; i++) push_beat(1, pkt[i]);
        rdy_q = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < NB; i++) push_beat(0, pkt[i]);
        run_until(base + 2, 100, n);
        chk("bp_order_first", order_q[order_q.size()-2], 1);
        chk("bp_order_second", order_q[order_q.size()-1], 0);

        // Random traffic, stalls and back-pressure; enough bad ones to saturate.
        p_valid = 70;
        p_rdy   = 70;
        base    = m_done;
        for (int i = 0; i < 75; i++) begin
            gen_tx(0, $urandom_range(99) < 40);
            gen_tx(1, $urandom_range(99) < 60);
        end
        run_until(base + 150, 20000, n);
        chk("saturated_count", bus.bad_count, CRC_EN ? CNT_MAX : 0);

        // Reset in the middle of a transaction.
        p_valid = 100;
        p_rdy   = 100;
        gen_tx(0, 0);
        n = 0;
        while (!(m_busy && m_idx == 3) && n < 50) begin step(); n++; end
        chk("midrst_reached_beat3", m_busy && m_idx == 3, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_last", bus.out_last, 0);
        chk("midrst_readies", {bus.req0_ready, bus.req1_ready}, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_out_src", bus.out_src, 0);
        chk("midrst_bad_count", bus.bad_count, 0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        gen_tx(0, 0);
        gen_tx(1, 0);
        run_until(m_done + 2, 100, n);
        chk("postrst_first_grant", order_q[0], 0);
        chk("postrst_second_grant", order_q[1], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tr_stream_arbiter.md
# tr_stream_arbiter

Two-requester, packet-locked, round-robin arbiter that shares the single DUT transaction channel between the normal transaction stream and the error-injection stream, both driven from the class-based generator/test environment. It forwards whole transactions (header, payload, checksum) without interleaving. It optionally checks each transaction's XOR checksum, flags corrupted ("bad") transactions on the last beat and counts them.

## Interface
Parameters:
- `DW`, 32, beat width in bits; header beat is `{src[DW/2-1:0], dst[DW/2-1:0]}`.
- `PKT_WORDS`, 4, payload beats per transaction, ≥1. Total beats per transaction = `PKT_WORDS+2`.
- `CNT_W`, 16, width of `bad_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 (normal stream) beat valid.
- `req0_data`  in  DW  requester 0 beat.
- `req0_ready`  out  1  requester 0 beat accepted when high with `req0_valid`.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1 (error-injection stream).
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DW  output beat.
- `out_ready`  in  1  downstream accepts beat.
- `out_last`  out  1  current beat is the checksum beat.
- `out_src`  out  1  index of the granted requester.
- `out_bad`  out  1  checksum mismatch, valid only with `out_last`.
- `bad_count`  out  CNT_W  saturating count of bad transactions transferred.
- `busy`  out  1  grant held (state GRANT).

## Operation
- State machine has two states: IDLE and GRANT.
- IDLE:
  - All readies are 0 and `out_valid` is 0.
  - If any `reqN_valid`, register the grant and go to GRANT.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester that is not `last_grant`.
- GRANT: zero-latency combinational pass-through of the granted requester only.
  - `out_valid` = `reqG_valid`, `out_data` = `reqG_data`, `reqG_ready` = `out_ready`.
  - The other requester's ready is held at 0.
- Beat counter `beat`:
  - 0 to `PKT_WORDS+1`.
  - Increments on each output handshake (`out_valid & out_ready`).
  - `out_last` = (`beat == PKT_WORDS+1`).
- A handshake on the last beat does three things: return to IDLE, set `last_grant` to the granted index, and clear `beat`.
- Grant is never changed mid-transaction, regardless of the other requester.
- Checksum:
  - Running XOR `acc` of the header beat and all payload beats, cleared on entry to GRANT.
  - On the last beat, `out_bad` = (`out_data != acc`).
  - `bad_count` increments on a last-beat handshake with `out_bad`=1 and saturates at all-ones.
- Reset values:
  - State IDLE; `beat`=0; `acc`=0; `last_grant`=1, so requester 0 wins the first tie.
  - `bad_count`=0.
  - All of `out_valid`, `out_last`, `out_bad`, `req0_ready`, `req1_ready`, `busy`, `out_src` = 0.
- Reset mid-transaction: the partial transaction is abandoned, the output drops immediately (asynchronous), and no count is updated.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at edge N gives `busy`=1 after N, and the first beat can transfer in cycle N+1.
- After a last-beat handshake at edge M, the state is IDLE in cycle M+1 (one bubble). The earliest next grant is at edge M+1 and the earliest next beat is in cycle M+2.
- Minimum transaction occupancy is `PKT_WORDS+3` cycles, including arbitration and the bubble.
- Back-pressure (`out_ready`=0) or a requester stall (`valid`=0) holds `beat` and `acc`, with no timeout.
- Payload transfer has no added latency; `out_*` are combinational from the granted input in GRANT.
- `bad_count` updates on the edge of the last-beat handshake and is visible the next cycle.

## Configuration
- `TR_ARB_CRC_CHECK_EN` defined: checksum logic as described above; `out_bad` and `bad_count` are live.
- Not defined:
  - `acc` and the compare logic are removed.
  - `out_bad` is tied to 0 and `bad_count` is tied to 0.
  - Arbitration and transfer timing are identical.

## Test plan
With `DW`=32 and `PKT_WORDS`=4:
- Single requester: req0 sends header 0x00010002, payload 1,2,3,4, checksum 0x00010006, with `out_ready`=1 → 6 beats out in consecutive cycles starting the cycle after the request; `out_src`=0, `out_last` on beat 6, `out_bad`=0, `bad_count`=0.
- Tie, then alternation: both requesters hold continuous valid transactions → grant order after reset is 0,1,0,1. There is exactly one idle cycle between transactions, and beats are never interleaved.
- Bad checksum: req1 sends the same transaction with checksum 0xDEADBEEF → `out_bad`=1 on the last beat and `bad_count`=1 the next cycle. With the macro undefined, `out_bad`=0 and `bad_count`=0.
- Back-pressure: toggle `out_ready` 1,0,0,1 during the payload, and have req0 raise valid mid-transaction → `beat` holds while `out_ready`=0, the data sequence is unchanged, and `req0_ready` stays 0 until the grant transfers.
- Saturation: 65537 bad transactions → `bad_count` stops at 0xFFFF.
- Reset mid-transaction: assert `rst_n`=0 after beat 3 → outputs and readies are 0 immediately, and `bad_count` is 0. After release, a tie grants requester 0 and a fresh 6-beat transaction completes correctly.
